vi_mem_model_pl: RTL and testbench
==================================

Name: vi_mem_model_pl

Overview:
- Parametrised, synthesizable line-based main-memory model for vi_core simulation and FPGA bring-up.
- Successor to the fixed 128-bit, 1-cycle memory model:
  - configurable line width, depth and read latency;
  - fully pipelined reads, one per cycle;
  - byte/half/word/line write sizes;
  - error pulse on misaligned or out-of-range writes.
- Sits between vi_core's memory interface and the backing array.

Parameters:
- LINE_W, 128, line width in bits; power of two, >= 32.
- ADDR_W, 20, byte address width.
- DEPTH, 65536, number of lines; must be <= 2^(ADDR_W - OFF_W).
- LATENCY, 1, cycles from read request edge to mem_data_ready_o; range 1..16.
- Derived: OFF_W = log2(LINE_W/8); IDX_W = ADDR_W - OFF_W.

Ports:
- clk_i  in  1  clock.
- rsn_i  in  1  reset: synchronous, active-low.
- mem_read_i  in  1  read request, sampled every rising edge.
- mem_read_addr_i  in  ADDR_W  read byte address; offset bits ignored.
- mem_write_enable_i  in  1  write request.
- mem_write_size_i  in  2  write size: 00 byte, 01 half, 10 word, 11 line.
- mem_write_addr_i  in  ADDR_W  write byte address.
- mem_write_data_i  in  LINE_W  write data; sub-line sizes use the low bits.
- mem_data_ready_o  out  1  read response valid.
- mem_data_o  out  LINE_W  read response line.
- mem_addr_o  out  ADDR_W  echo of the request address (full, offset included).
- mem_write_err_o  out  1  one-cycle pulse when a write is rejected.

Behaviour:
- Reset (rsn_i low at an edge):
  - all pipeline valids cleared;
  - mem_data_ready_o, mem_data_o, mem_addr_o, mem_write_err_o all 0;
  - array contents not reset;
  - in-flight reads are dropped and never produce a response.
- Read path:
  - At edge T with mem_read_i=1, line idx = addr[ADDR_W-1:OFF_W] is read from the array (read-before-write, see below).
  - The read enters a LATENCY-stage in-order delay line.
  - mem_data_ready_o=1 with data and address after edge T+LATENCY-1, i.e. visible during cycle T+LATENCY. LATENCY=1 gives a response in the cycle after the request.
  - One request accepted per cycle, no backpressure, responses in issue order.
  - mem_data_ready_o is 0 in any cycle with no emerging request; mem_data_o and mem_addr_o hold their last values.
  - If idx >= DEPTH: response still issued, mem_data_o = 0.
- Write path (applied at the request edge):
  - byte: data[7:0] -> line bits [off*8 +: 8].
  - half: requires addr[0]=0; data[15:0] -> [off[OFF_W-1:1]*16 +: 16].
  - word: requires addr[1:0]=0; data[31:0] -> [off[OFF_W-1:2]*32 +: 32].
  - line: requires off=0; full data written.
  - Untouched bytes of the line are preserved.
- Rejection:
  - Misaligned or idx >= DEPTH → write ignored and mem_write_err_o=1 for exactly the next cycle.
  - Otherwise mem_write_err_o=0.
- Simultaneous read and write, same edge:
  - Same line: the read returns the pre-write contents (read-old).
  - Different lines: both proceed independently.
- A write at edge T+k, 0<k<LATENCY, does not alter data of a read issued at T. Data is captured at issue.
- Reset asserted on the same edge as a read or write request: the request is discarded and the array is unchanged.

Decomposition:
- Package vi_mem_pkg:
  - size encodings MEM_SZ_BYTE/HALF/WORD/LINE;
  - default LINE_W/ADDR_W localparams;
  - log2 function for OFF_W.
- Sub-module vi_mem_rd_pipe: parametrised LATENCY x {valid, addr, data} in-order delay line with synchronous active-low clear.
- Top level holds the array, write-merge logic and error detection.

Test Plan:
- LATENCY=1, line 0x100 preloaded {00311133,00F00193,00108113,001000B3}; read addr 0x01000 at T → ready=1 in cycle T+1 with that line and mem_addr_o=0x01000; ready=0 in cycle T+2.
- LATENCY=4, reads to 0x10000, 0x10010, 0x10020 on three consecutive edges → three consecutive ready cycles starting at T+4, in order, with the correct lines.
- Byte write 0xAB at 0x10005 over line all-0x02 words → subsequent read gives word1 = 0x0000AB02, other bytes unchanged.
- Word write 0xDEADBEEF at 0x10006 (misaligned) → mem_write_err_o=1 for one cycle, line unchanged; word write at 0x10008 → err=0, word2 = DEADBEEF.
- Read and line write to 0x20000 on the same edge → response holds old line; a read on the next edge returns the new line.
- LATENCY=3, two reads in flight, rsn_i=0 for one edge → no responses ever appear, all outputs 0; after release a new read completes normally.

Source files
------------

// File: rtl/vi_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vi_mem_pkg                                                           |
// | Shared encodings and defaults for the vi_core line memory model.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package vi_mem_pkg;

    localparam logic [1:0] MEM_SZ_BYTE = 2'b00;
    localparam logic [1:0] MEM_SZ_HALF = 2'b01;
    localparam logic [1:0] MEM_SZ_WORD = 2'b10;
    localparam logic [1:0] MEM_SZ_LINE = 2'b11;

    localparam int VI_MEM_LINE_W = 128;
    localparam int VI_MEM_ADDR_W = 20;

    // Smallest r with 2**r >= value; elaboration-time only.
    function automatic int vi_mem_log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vi_mem_rd_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vi_mem_rd_pipe                                                       |
// | In-order LATENCY-stage delay line carrying {valid, addr, data}.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module vi_mem_rd_pipe #(
    parameter int LATENCY = 1,
    parameter int ADDR_W  = 20,
    parameter int LINE_W  = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LINE_W-1:0] i_data,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr,
    output logic [LINE_W-1:0] o_data
);

    logic [LATENCY-1:0]             r_vld;
    logic [LATENCY-1:0][ADDR_W-1:0] r_addr;
    logic [LATENCY-1:0][LINE_W-1:0] r_data;

    // Payload only moves with a valid token, so the last stage holds its
    // value through idle cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld  <= '0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_vld[0] <= i_valid;
            if (i_valid) begin
                r_addr[0] <= i_addr;
                r_data[0] <= i_data;
            end
            for (int s = 1; s < LATENCY; s++) begin
                r_vld[s] <= r_vld[s-1];
                if (r_vld[s-1]) begin
                    r_addr[s] <= r_addr[s-1];
                    r_data[s] <= r_data[s-1];
                end
            end
        end
    end

    assign o_valid = r_vld[LATENCY-1];
    assign o_addr  = r_addr[LATENCY-1];
    assign o_data  = r_data[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/vi_mem_model_pl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vi_mem_model_pl                                                      |
// | Pipelined line memory model: sized writes, read-old, error pulse.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module vi_mem_model_pl
    import vi_mem_pkg::*;
#(
    parameter int LINE_W  = VI_MEM_LINE_W,
    parameter int ADDR_W  = VI_MEM_ADDR_W,
    parameter int DEPTH   = 65536,
    parameter int LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic              mem_read_i,
    input  logic [ADDR_W-1:0] mem_read_addr_i,
    input  logic              mem_write_enable_i,
    input  logic [1:0]        mem_write_size_i,
    input  logic [ADDR_W-1:0] mem_write_addr_i,
    input  logic [LINE_W-1:0] mem_write_data_i,
    output logic              mem_data_ready_o,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_write_err_o
);

    localparam int c_NB    = LINE_W / 8;
    localparam int c_OFF_W = vi_mem_log2(c_NB);
    localparam int c_IDX_W = ADDR_W - c_OFF_W;
    localparam int c_ARR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [LINE_W-1:0] r_mem [DEPTH];
    logic              r_wr_err;

    logic [c_IDX_W-1:0] w_rd_idx;
    logic               w_rd_in_range;
    logic [LINE_W-1:0]  w_rd_data;

    assign w_rd_idx      = mem_read_addr_i[ADDR_W-1:c_OFF_W];
    assign w_rd_in_range = ({1'b0, w_rd_idx} < (c_IDX_W+1)'(DEPTH));
    // Sampled before this edge's write lands, which gives read-old semantics.
    assign w_rd_data     = w_rd_in_range ? r_mem[w_rd_idx[c_ARR_W-1:0]] : '0;

    vi_mem_rd_pipe #(
        .LATENCY (LATENCY),
        .ADDR_W  (ADDR_W),
        .LINE_W  (LINE_W)
    ) u_rd_pipe (
        .clk     (clk_i),
        .rst_n   (rsn_i),
        .i_valid (mem_read_i),
        .i_addr  (mem_read_addr_i),
        .i_data  (w_rd_data),
        .o_valid (mem_data_ready_o),
        .o_addr  (mem_addr_o),
        .o_data  (mem_data_o)
    );

    logic [c_OFF_W-1:0] w_wr_off;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic               w_wr_in_range;
    logic               w_wr_aligned;
    logic               w_wr_ok;
    logic               w_wr_fire;
    logic [c_NB-1:0]    w_wr_be;
    logic [LINE_W-1:0]  w_wr_line;

    assign w_wr_off      = mem_write_addr_i[c_OFF_W-1:0];
    assign w_wr_idx      = mem_write_addr_i[ADDR_W-1:c_OFF_W];
    assign w_wr_in_range = ({1'b0, w_wr_idx} < (c_IDX_W+1)'(DEPTH));

    // Sub-line data is replicated across the line; the byte enables pick
    // the lane, so no per-size shifter on the data path is needed.
    always_comb begin
        w_wr_aligned = 1'b1;
        w_wr_be      = '0;
        w_wr_line    = '0;
        case (mem_write_size_i)
            MEM_SZ_BYTE: begin
                w_wr_be   = c_NB'(1) << w_wr_off;
                w_wr_line = {c_NB{mem_write_data_i[7:0]}};
            end
            MEM_SZ_HALF: begin
                w_wr_aligned = (w_wr_off[0] == 1'b0);
                w_wr_be      = c_NB'(2'b11) << w_wr_off;
                w_wr_line    = {(c_NB/2){mem_write_data_i[15:0]}};
            end
            MEM_SZ_WORD: begin
                w_wr_aligned = (w_wr_off[1:0] == 2'b00);
                w_wr_be      = c_NB'(4'hF) << w_wr_off;
                w_wr_line    = {(c_NB/4){mem_write_data_i[31:0]}};
            end
            default: begin
                w_wr_aligned = (w_wr_off == '0);
                w_wr_be      = '1;
                w_wr_line    = mem_write_data_i;
            end
        endcase
    end

    assign w_wr_ok   = w_wr_aligned & w_wr_in_range;
    assign w_wr_fire = mem_write_enable_i & rsn_i & w_wr_ok;

    always_ff @(posedge clk_i) begin
        if (w_wr_fire) begin
            for (int b = 0; b < c_NB; b++) begin
                if (w_wr_be[b]) begin
                    r_mem[w_wr_idx[c_ARR_W-1:0]][b*8 +: 8] <= w_wr_line[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= mem_write_enable_i & ~w_wr_ok;
        end
    end

    assign mem_write_err_o = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_vi_mem_model_pl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vi_mem_model_pl                                                   |
// | Directed bench: three latencies driven from one shared stimulus.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_vi_mem_model_pl;

    localparam int c_LW = 128;
    localparam int c_AW = 20;
    localparam int c_DP = 16384;

    logic            clk;
    logic            rsn;
    logic            rd;
    logic [c_AW-1:0] rd_addr;
    logic            we;
    logic [1:0]      wsz;
    logic [c_AW-1:0] wa;
    logic [c_LW-1:0] wd;

    logic            rdy1, rdy3, rdy4;
    logic [c_LW-1:0] data1, data3, data4;
    logic [c_AW-1:0] addr1, addr3, addr4;
    logic            err1, err3, err4;

    int n_checks;
    int n_errors;

    localparam logic [c_LW-1:0] c_L100 = 128'h00311133_00F00193_00108113_001000B3;
    localparam logic [c_LW-1:0] c_LA   = {4{32'h00000002}};
    localparam logic [c_LW-1:0] c_LB   = 128'hB0B0B0B0_B1B1B1B1_B2B2B2B2_B3B3B3B3;
    localparam logic [c_LW-1:0] c_LC   = 128'hC0000000_C1111111_C2222222_C3333333;
    localparam logic [c_LW-1:0] c_OLD  = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [c_LW-1:0] c_NEW  = 128'h5555AAAA_6666BBBB_7777CCCC_8888DDDD;

    vi_mem_model_pl #(.LINE_W(c_LW), .ADDR_W(c_AW), .DEPTH(c_DP), .LATENCY(1)) u_l1 (
        .clk_i(clk), .rsn_i(rsn), .mem_read_i(rd), .mem_read_addr_i(rd_addr),
        .mem_write_enable_i(we), .mem_write_size_i(wsz), .mem_write_addr_i(wa),
        .mem_write_data_i(wd), .mem_data_ready_o(rdy1), .mem_data_o(data1),
        .mem_addr_o(addr1), .mem_write_err_o(err1));

    vi_mem_model_pl #(.LINE_W(c_LW), .ADDR_W(c_AW), .DEPTH(c_DP), .LATENCY(3)) u_l3 (
        .clk_i(clk), .rsn_i(rsn), .mem_read_i(rd), .mem_read_addr_i(rd_addr),
        .mem_write_enable_i(we), .mem_write_size_i(wsz), .mem_write_addr_i(wa),
        .mem_write_data_i(wd), .mem_data_ready_o(rdy3), .mem_data_o(data3),
        .mem_addr_o(addr3), .mem_write_err_o(err3));

    vi_mem_model_pl #(.LINE_W(c_LW), .ADDR_W(c_AW), .DEPTH(c_DP), .LATENCY(4)) u_l4 (
        .clk_i(clk), .rsn_i(rsn), .mem_read_i(rd), .mem_read_addr_i(rd_addr),
        .mem_write_enable_i(we), .mem_write_size_i(wsz), .mem_write_addr_i(wa),
        .mem_write_data_i(wd), .mem_data_ready_o(rdy4), .mem_data_o(data4),
        .mem_addr_o(addr4), .mem_write_err_o(err4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [c_LW-1:0] act, input logic [c_LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] sz, input logic [c_AW-1:0] a, input logic [c_LW-1:0] d);
        we  = 1'b1;
        wsz = sz;
        wa  = a;
        wd  = d;
        tick();
        we  = 1'b0;
    endtask

    task automatic rd_one(input logic [c_AW-1:0] a);
        rd      = 1'b1;
        rd_addr = a;
        tick();
        rd      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rsn = 1'b0; rd = 1'b0; rd_addr = '0;
        we = 1'b0; wsz = 2'b00; wa = '0; wd = '0;
        idle(2);
        check("rst_ready", c_LW'(rdy1), 128'd0);
        check("rst_data",  data1, 128'd0);
        check("rst_addr",  c_LW'(addr1), 128'd0);
        check("rst_err",   c_LW'(err1), 128'd0);
        rsn = 1'b1;

        wr(2'b11, 20'h01000, c_L100);
        wr(2'b11, 20'h10000, c_LA);
        wr(2'b11, 20'h10010, c_LB);
        wr(2'b11, 20'h10020, c_LC);
        wr(2'b11, 20'h20000, c_OLD);
        check("line_wr_err", c_LW'(err1), 128'd0);
        idle(5);

        // LATENCY=1 single read
        rd_one(20'h01000);
        check("l1_ready", c_LW'(rdy1), 128'd1);
        check("l1_data",  data1, c_L100);
        check("l1_addr",  c_LW'(addr1), c_LW'(20'h01000));
        tick();
        check("l1_ready_drop", c_LW'(rdy1), 128'd0);
        check("l1_data_hold",  data1, c_L100);
        idle(5);

        // LATENCY=4 back-to-back reads
        rd = 1'b1; rd_addr = 20'h10000; tick();
        check("l4_wait0", c_LW'(rdy4), 128'd0);
        rd_addr = 20'h10010; tick();
        check("l4_wait1", c_LW'(rdy4), 128'd0);
        rd_addr = 20'h10020; tick();
        check("l4_wait2", c_LW'(rdy4), 128'd0);
        check("l3_first", data3, c_LA);
        rd = 1'b0; tick();
        check("l4_rdy_a",  c_LW'(rdy4), 128'd1);
        check("l4_data_a", data4, c_LA);
        check("l4_addr_a", c_LW'(addr4), c_LW'(20'h10000));
        tick();
        check("l4_rdy_b",  c_LW'(rdy4), 128'd1);
        check("l4_data_b", data4, c_LB);
        tick();
        check("l4_rdy_c",  c_LW'(rdy4), 128'd1);
        check("l4_data_c", data4, c_LC);
        check("l4_addr_c", c_LW'(addr4), c_LW'(20'h10020));
        tick();
        check("l4_rdy_end", c_LW'(rdy4), 128'd0);
        idle(5);

        // Byte write into the middle of a line
        wr(2'b00, 20'h10005, 128'hAB);
        check("byte_err", c_LW'(err1), 128'd0);
        rd_one(20'h10000);
        check("byte_line", data1, 128'h00000002_00000002_0000AB02_00000002);

        // Misaligned word write is rejected for one cycle only
        wr(2'b10, 20'h10006, 128'hDEADBEEF);
        check("word_mis_err", c_LW'(err1), 128'd1);
        tick();
        check("word_mis_clr", c_LW'(err1), 128'd0);
        rd_one(20'h10000);
        check("word_mis_line", data1, 128'h00000002_00000002_0000AB02_00000002);
        wr(2'b10, 20'h10008, 128'hDEADBEEF);
        check("word_ok_err", c_LW'(err1), 128'd0);
        rd_one(20'h10000);
        check("word_ok_line", data1, 128'h00000002_DEADBEEF_0000AB02_00000002);

        // Half-word: misaligned then aligned
        wr(2'b01, 20'h10001, 128'h1234);
        check("half_mis_err", c_LW'(err1), 128'd1);
        wr(2'b01, 20'h10002, 128'h1234);
        check("half_ok_err", c_LW'(err1), 128'd0);
        rd_one(20'h10000);
        check("half_line", data1, 128'h00000002_DEADBEEF_0000AB02_12340002);

        // Out-of-range index
        wr(2'b11, 20'h40000, c_NEW);
        check("oor_wr_err", c_LW'(err1), 128'd1);
        rd_one(20'h40000);
        check("oor_rd_rdy",  c_LW'(rdy1), 128'd1);
        check("oor_rd_data", data1, 128'd0);
        check("oor_rd_addr", c_LW'(addr1), c_LW'(20'h40000));

        // Same-edge read and line write to one line: read returns old data
        rd = 1'b1; rd_addr = 20'h20000;
        we = 1'b1; wsz = 2'b11; wa = 20'h20000; wd = c_NEW;
        tick();
        we = 1'b0;
        check("rw_old", data1, c_OLD);
        tick();
        rd = 1'b0;
        check("rw_new", data1, c_NEW);
        idle(5);

        // Reset with reads in flight plus a same-edge read and write
        rd = 1'b1; rd_addr = 20'h01000; tick();
        rd_addr = 20'h10000; tick();
        check("l3_inflight", c_LW'(rdy3), 128'd0);
        rsn = 1'b0; rd_addr = 20'h01000;
        we = 1'b1; wsz = 2'b11; wa = 20'h01000; wd = '1;
        tick();
        check("rst3_ready", c_LW'(rdy3), 128'd0);
        check("rst3_data",  data3, 128'd0);
        check("rst3_addr",  c_LW'(addr3), 128'd0);
        check("rst3_err",   c_LW'(err3), 128'd0);
        rsn = 1'b1; rd = 1'b0; we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst3_dropped", c_LW'(rdy3), 128'd0);
        end
        rd_one(20'h01000);
        check("post_rst_w0", c_LW'(rdy3), 128'd0);
        tick();
        check("post_rst_w1", c_LW'(rdy3), 128'd0);
        tick();
        check("post_rst_rdy",  c_LW'(rdy3), 128'd1);
        check("post_rst_data", data3, c_L100);
        check("post_rst_addr", c_LW'(addr3), c_LW'(20'h01000));
        check("post_rst_err",  c_LW'(err3), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
